// File: rtl/alu_decode_stage_if.sv
// Decode-stage bus: instruction handshake, writeback port, flush and ALU-side outputs.
interface alu_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_op;
    logic [31:0] ex_rv1;
    logic [31:0] ex_rv2;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        ex_illegal;

    // Upstream/environment side.
    modport master (
        output in_valid, instr, wb_en, wb_rd, wb_data, flush, ex_ready,
        input  in_ready, ex_valid, ex_op, ex_rv1, ex_rv2, ex_rd, ex_we, ex_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, instr, wb_en, wb_rd, wb_data, flush, ex_ready,
        output in_ready, ex_valid, ex_op, ex_rv1, ex_rv2, ex_rd, ex_we, ex_illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I OP/OP-IMM decode with 32x32 register file and one-entry output register to the ALU.
module alu_decode_stage (
    input  logic                clk,
    input  logic                reset,
    alu_decode_stage_if.slave   bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned OPW  = 6;
    localparam int unsigned RW   = 5;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    logic [XLEN-1:0] rf [NREG];

    logic            ex_valid_q;
    logic [OPW-1:0]  ex_op_q;
    logic [XLEN-1:0] ex_rv1_q;
    logic [XLEN-1:0] ex_rv2_q;
    logic [RW-1:0]   ex_rd_q;
    logic            ex_we_q;
    logic            ex_illegal_q;

    logic            accept;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            is_shift;
    logic            legal;
    logic [OPW-1:0]  dec_op;
    logic [XLEN-1:0] dec_rv2;

    assign opcode = bus.instr[6:0];
    assign rd     = bus.instr[11:7];
    assign funct3 = bus.instr[14:12];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign funct7 = bus.instr[31:25];

    assign bus.in_ready = (!ex_valid_q || bus.ex_ready) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;

    // Register read with x0 hardwired to zero and same-cycle writeback bypass.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != '0) begin
            rs1_val = (bus.wb_en && bus.wb_rd == rs1) ? bus.wb_data : rf[rs1];
        end
        if (rs2 != '0) begin
            rs2_val = (bus.wb_en && bus.wb_rd == rs2) ? bus.wb_data : rf[rs2];
        end
    end

    // Legality check, ALU op map and operand-2 selection.
    always_comb begin
        legal    = 1'b0;
        dec_op   = '0;
        dec_rv2  = '0;
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

        if (opcode == OPC_OP) begin
            legal = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        end else if (opcode == OPC_OPIMM) begin
            unique case (funct3)
                3'b001:  legal = (funct7 == 7'b0000000);
                3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                default: legal = 1'b1;
            endcase
        end

        unique case (funct3)
            3'b000:  dec_op = (opcode == OPC_OP && bus.instr[30]) ? 6'b110000 : 6'b000000;
            3'b001:  dec_op = 6'b100000;
            3'b010:  dec_op = 6'b000010;
            3'b011:  dec_op = 6'b000011;
            3'b100:  dec_op = 6'b000100;
            3'b101:  dec_op = bus.instr[30] ? 6'b110101 : 6'b100101;
            3'b110:  dec_op = 6'b000110;
            default: dec_op = 6'b000111;
        endcase

        // Shift amounts are masked to 5 bits so the ALU sees RV32 semantics.
        if (opcode == OPC_OP) begin
            dec_rv2 = is_shift ? {27'b0, rs2_val[4:0]} : rs2_val;
        end else begin
            dec_rv2 = is_shift ? {27'b0, rs2} : {{20{bus.instr[31]}}, bus.instr[31:20]};
        end
    end

    // Register file: cleared on reset, writes to x0 ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf[i] <= '0;
            end
        end else if (bus.wb_en && bus.wb_rd != '0) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Output pipeline register: load on accept, drain on consume, hold on stall, kill on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_op_q      <= '0;
            ex_rv1_q     <= '0;
            ex_rv2_q     <= '0;
            ex_rd_q      <= '0;
            ex_we_q      <= 1'b0;
            ex_illegal_q <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_q   <= 1'b0;
        end else if (accept) begin
            ex_valid_q   <= 1'b1;
            ex_rd_q      <= rd;
            ex_illegal_q <= !legal;
            ex_op_q      <= legal ? dec_op : '0;
            ex_rv1_q     <= legal ? rs1_val : '0;
            ex_rv2_q     <= legal ? dec_rv2 : '0;
            ex_we_q      <= legal && (rd != '0);
        end else if (bus.ex_ready) begin
            ex_valid_q   <= 1'b0;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_op      = ex_op_q;
    assign bus.ex_rv1     = ex_rv1_q;
    assign bus.ex_rv2     = ex_rv2_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_we      = ex_we_q;
    assign bus.ex_illegal = ex_illegal_q;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage.
module tb_alu_decode_stage;
    logic clk;
    logic reset;
    int   checks;
    int   fails;

    alu_decode_stage_if bus ();

    alu_decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // R-type encoder (OP opcode).
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // I-type encoder with selectable opcode.
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    // Packs the expected output bundle {valid, op, rv1, rv2, rd, we, illegal}.
    function automatic logic [77:0] ex(input logic v, input logic [5:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd,
                                       input logic we, input logic ill);
        return {v, op, a, b, rd, we, ill};
    endfunction

    function automatic logic [77:0] obs();
        return {bus.ex_valid, bus.ex_op, bus.ex_rv1, bus.ex_rv2, bus.ex_rd, bus.ex_we, bus.ex_illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = rd;
        bus.wb_data = data;
        tick();
        bus.wb_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (obs() !== ex(0, 0, 0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_state got=%h exp=%h", obs(), ex(0, 0, 0, 0, 0, 0, 0));
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_reg_op();
        logic [77:0] e;
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd3);
        send(32'h402081B3);
        e = ex(1, 6'b110000, 32'd5, 32'd3, 5'd3, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL sub_reg got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_imm();
        logic [77:0] e;
        send(enc_i(12'hFFF, 5'd0, 3'b000, 5'd4, 7'b0010011));
        e = ex(1, 6'b000000, 32'd0, 32'hFFFFFFFF, 5'd4, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL addi_neg got=%h exp=%h", obs(), e);
        end
        send(enc_i({7'b0100000, 5'd31}, 5'd1, 3'b101, 5'd5, 7'b0010011));
        e = ex(1, 6'b110101, 32'd5, 32'h1F, 5'd5, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL srai got=%h exp=%h", obs(), e);
        end
        send(enc_i({7'b0100000, 5'd3}, 5'd1, 3'b001, 5'd6, 7'b0010011));
        e = ex(1, 6'b000000, 32'd0, 32'd0, 5'd6, 0, 1);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL slli_bad got=%h exp=%h", obs(), e);
        end
        send(enc_i(12'hFFB, 5'd1, 3'b010, 5'd22, 7'b0010011));
        e = ex(1, 6'b000010, 32'd5, 32'hFFFFFFFB, 5'd22, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL slti got=%h exp=%h", obs(), e);
        end
        // addi with bit 30 set stays add
        send(enc_i(12'h400, 5'd1, 3'b000, 5'd23, 7'b0010011));
        e = ex(1, 6'b000000, 32'd5, 32'h400, 5'd23, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL addi_b30 got=%h exp=%h", obs(), e);
        end
        // register shift amount masked to 5 bits
        wb_write(5'd9, 32'h25);
        send(enc_r(7'b0000000, 5'd9, 5'd1, 3'b001, 5'd6));
        e = ex(1, 6'b100000, 32'd5, 32'd5, 5'd6, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL sll_mask got=%h exp=%h", obs(), e);
        end
        send(enc_r(7'b0100000, 5'd2, 5'd1, 3'b100, 5'd24));
        e = ex(1, 6'b000000, 32'd0, 32'd0, 5'd24, 0, 1);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL op_f7_bad got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_bypass();
        logic [77:0] e;
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd7;
        bus.wb_data = 32'hDEADBEEF;
        send(enc_r(7'b0, 5'd0, 5'd7, 3'b000, 5'd8));
        e = ex(1, 6'b000000, 32'hDEADBEEF, 32'd0, 5'd8, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL bypass_rs1 got=%h exp=%h", obs(), e);
        end
        bus.wb_rd   = 5'd0;
        bus.wb_data = 32'h1234;
        send(enc_r(7'b0, 5'd0, 5'd0, 3'b000, 5'd10));
        bus.wb_en = 1'b0;
        send(enc_r(7'b0, 5'd0, 5'd0, 3'b110, 5'd10));
        e = ex(1, 6'b000110, 32'd0, 32'd0, 5'd10, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL x0_read got=%h exp=%h", obs(), e);
        end
        send(enc_r(7'b0, 5'd0, 5'd7, 3'b000, 5'd18));
        e = ex(1, 6'b000000, 32'hDEADBEEF, 32'd0, 5'd18, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL x7_stored got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_stall();
        logic [77:0] ea;
        logic [77:0] eb;
        ea = ex(1, 6'b000000, 32'd5, 32'd3, 5'd13, 1, 0);
        eb = ex(1, 6'b000100, 32'd5, 32'd3, 5'd14, 1, 0);
        bus.ex_ready = 1'b1;
        send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd13));
        bus.ex_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr    = enc_r(7'b0, 5'd2, 5'd1, 3'b100, 5'd14);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== ea) begin
                fails++;
                $display("FAIL stall_hold%0d got=%h exp=%h", i, obs(), ea);
            end
        end
        bus.ex_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_in_ready got=%b exp=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== eb) begin
            fails++;
            $display("FAIL release_next got=%h exp=%h", obs(), eb);
        end
        tick();
        eb[77] = 1'b0;
        checks++;
        if (obs() !== eb) begin
            fails++;
            $display("FAIL drain_hold got=%h exp=%h", obs(), eb);
        end
    endtask

    task automatic test_flush();
        logic [77:0] ea;
        logic [77:0] eb;
        ea = ex(1, 6'b000000, 32'd5, 32'd0, 5'd15, 1, 0);
        eb = ex(1, 6'b000110, 32'd5, 32'hF0, 5'd16, 1, 0);
        bus.ex_ready = 1'b0;
        send(enc_r(7'b0, 5'd0, 5'd1, 3'b000, 5'd15));
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = enc_i(12'h0F0, 5'd1, 3'b110, 5'd16, 7'b0010011);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready);
        end
        tick();
        bus.flush = 1'b0;
        ea[77] = 1'b0;
        checks++;
        if (obs() !== ea) begin
            fails++;
            $display("FAIL flush_kill got=%h exp=%h", obs(), ea);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== eb) begin
            fails++;
            $display("FAIL flush_after got=%h exp=%h", obs(), eb);
        end
        bus.ex_ready = 1'b1;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle got=%b exp=0", bus.ex_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [77:0] e0;
        logic [77:0] e1;
        logic [77:0] e2;
        e0 = ex(1, 6'b000111, 32'd5, 32'd3, 5'd0, 0, 0);
        e1 = ex(1, 6'b000011, 32'd3, 32'd5, 5'd19, 1, 0);
        e2 = ex(1, 6'b100101, 32'd5, 32'd3, 5'd20, 1, 0);
        bus.ex_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = enc_r(7'b0, 5'd2, 5'd1, 3'b111, 5'd0);
        tick();
        bus.instr = enc_r(7'b0, 5'd1, 5'd2, 3'b011, 5'd19);
        checks++;
        if (obs() !== e0) begin
            fails++;
            $display("FAIL b2b_0 got=%h exp=%h", obs(), e0);
        end
        tick();
        bus.instr = enc_r(7'b0, 5'd2, 5'd1, 3'b101, 5'd20);
        checks++;
        if (obs() !== e1) begin
            fails++;
            $display("FAIL b2b_1 got=%h exp=%h", obs(), e1);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== e2) begin
            fails++;
            $display("FAIL b2b_2 got=%h exp=%h", obs(), e2);
        end
    endtask

    task automatic test_reset_mid();
        logic [77:0] e;
        bus.ex_ready = 1'b0;
        send(enc_r(7'b0, 5'd2, 5'd1, 3'b111, 5'd17));
        bus.in_valid = 1'b1;
        bus.instr    = enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd25);
        bus.wb_en    = 1'b1;
        bus.wb_rd    = 5'd2;
        bus.wb_data  = 32'h77;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        bus.wb_en    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== ex(0, 0, 0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL mid_reset got=%h exp=%h", obs(), ex(0, 0, 0, 0, 0, 0, 0));
        end
        bus.ex_ready = 1'b1;
        send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd11));
        e = ex(1, 6'b000000, 32'd0, 32'd0, 5'd11, 1, 0);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL rf_cleared got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_illegal_load();
        logic [77:0] e;
        wb_write(5'd1, 32'd9);
        send(enc_i(12'h004, 5'd1, 3'b010, 5'd12, 7'b0000011));
        e = ex(1, 6'b000000, 32'd0, 32'd0, 5'd12, 0, 1);
        checks++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL load_illegal got=%h exp=%h", obs(), e);
        end
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.instr    = '0;
        bus.wb_en    = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        test_reset();
        test_reg_op();
        test_imm();
        test_bypass();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_illegal_load();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
